dmem_arbiter: RTL
=================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, DMEM word-address width.
REQ-002 Parameter DATA_W, default 32, DMEM data width.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset; no other clock or reset inputs.
REQ-004 dmem_arbiter_clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 dmem_arbiter_rst_n  in  1  asynchronous, active-low reset.
REQ-006 dmem_arbiter_req0 / _req1  in  1 each  access request from requester 0 / 1.
REQ-007 dmem_arbiter_we0 / _we1  in  1 each  1 = write, 0 = read.
REQ-008 dmem_arbiter_addr0 / _addr1  in  ADDR_W each  word address.
REQ-009 dmem_arbiter_wdata0 / _wdata1  in  DATA_W each  write data.
REQ-010 dmem_arbiter_ack0 / _ack1  out  1 each  one-cycle completion pulse.
REQ-011 dmem_arbiter_rdata0 / _rdata1  out  DATA_W each  read data, valid while the matching ack is high.
REQ-012 dmem_arbiter_mem_address  out  ADDR_W  to DMEM address.
REQ-013 dmem_arbiter_mem_data_in  out  DATA_W  to DMEM write data.
REQ-014 dmem_arbiter_mem_write / _mem_read  out  1 each  DMEM write and read enables.
REQ-015 dmem_arbiter_mem_data_out  in  DATA_W  combinational read data from DMEM.

Function
REQ-016 The FSM SHALL have states IDLE, ACCESS and RESP, encoded in 2 bits.
REQ-017 In IDLE, with any req high, the arbiter SHALL pick a winner, latch its we/addr/wdata and index, and go to ACCESS next edge; with no req it SHALL stay in IDLE.
REQ-018 Arbitration SHALL be round-robin: one req high wins; both high, the requester named by 1-bit pointer prio wins, then prio becomes the loser's index.
REQ-019 In ACCESS, for exactly one cycle, mem_address/mem_data_in SHALL carry the latched values, mem_write = latched we, mem_read = !latched we; the FSM goes to RESP.
REQ-020 On a read, mem_data_out SHALL be captured into a read register on the ACCESS-to-RESP edge; a write commits on that same edge.
REQ-021 In RESP the winner's ack SHALL be 1 for one cycle, its rdata = the read register (last captured value after a write), and the FSM returns to IDLE.
REQ-022 Latency SHALL be fixed: req seen in IDLE at edge N, DMEM access in cycle N+1, ack in cycle N+2; peak throughput is one access per 3 cycles.
REQ-023 Outside ACCESS, mem_write and mem_read SHALL be 0 and mem_address/mem_data_in SHALL hold their last values.
REQ-024 Requests arriving or changing in ACCESS/RESP SHALL be ignored until the next IDLE; a req dropped after latching SHALL still complete and ack.
REQ-025 Requesters SHALL hold req until ack; a req still high in the cycle after ack is treated as a new request.
REQ-026 At most one ack SHALL be high in any cycle, never outside RESP.

Reset
REQ-027 Reset asserted SHALL force, at once: state IDLE, prio 0, ack0/ack1 0, mem_write/mem_read 0, mem_address 0, mem_data_in 0, rdata0/rdata1 and read register 0.
REQ-028 Reset in ACCESS or RESP SHALL abandon the transfer with no ack; a write not yet past its commit edge SHALL not commit.
REQ-029 After rst_n deasserts, the first arbitration SHALL be on the first rising edge with rst_n high.

Structure
REQ-030 A shared package SHALL hold the state enumeration (IDLE, ACCESS, RESP) and the ADDR_W/DATA_W defaults.
REQ-031 The round-robin winner selection and prio update SHALL be one sub-module, dmem_rr_pick (inputs req0, req1, prio; outputs grant index and valid).

Verification
REQ-032 Read: req0=1, we0=0, addr0=0x10, DMEM[0x10]=0xDEADBEEF -> mem_read=1 with address 0x10 in cycle N+1; ack0=1, rdata0=0xDEADBEEF in N+2; ack1 stays 0.
REQ-033 Write-then-read: req1 writes 0xCAFEF00D to 0x20, then reads 0x20 -> mem_write pulse of one cycle, ack1 at N+2, read returns 0xCAFEF00D.
REQ-034 Contention: req0=req1=1 held for 4 transfers from reset -> grants 0,1,0,1; acks 3 cycles apart, never both high.
REQ-035 Reset mid-write: rst_n low during ACCESS of a write of 0x12345678 to 0x30 holding 0x0 -> no ack, mem_write 0 at once, DMEM[0x30] still 0x0, next arbitration grants requester 0.
REQ-036 Early drop: req0 pulsed for one cycle in IDLE -> transfer completes, ack0 at N+2; req1 arriving during ACCESS served in the next IDLE.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared types and defaults for the DMEM arbiter
// Holds the arbiter state enumeration and the default address/data widths.
package dmem_arbiter_pkg;

    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_rr_pick.sv
// rtl/dmem_rr_pick.sv - two-way round-robin winner selection
// Ports:
//   req0, req1  in   requests from requester 0 / 1
//   prio        in   requester favoured when both request
//   grant       out  index of the winning requester
//   valid       out  at least one request is present
//   prio_next   out  priority pointer to keep if this pick is taken
module dmem_rr_pick (
    input  logic req0,
    input  logic req1,
    input  logic prio,
    output logic grant,
    output logic valid,
    output logic prio_next
);

    always_comb begin
        valid     = req0 | req1;
        grant     = 1'b0;
        prio_next = prio;
        if (req0 && req1) begin
            grant     = prio;
            // The loser gets priority next time both contend.
            prio_next = ~prio;
        end else if (req1) begin
            grant = 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester round-robin arbiter in front of a single-port DMEM
// Ports:
//   dmem_arbiter_clk / _rst_n         clock, asynchronous active-low reset
//   dmem_arbiter_req*/we*/addr*/wdata* requester 0/1 access requests
//   dmem_arbiter_ack* / rdata*        one-cycle completion pulse and read data
//   dmem_arbiter_mem_*                DMEM address, write data, enables, read data
// Every access takes exactly three cycles: IDLE (arbitrate), ACCESS (DMEM cycle),
// RESP (ack).
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              dmem_arbiter_clk,
    input  logic              dmem_arbiter_rst_n,
    input  logic              dmem_arbiter_req0,
    input  logic              dmem_arbiter_req1,
    input  logic              dmem_arbiter_we0,
    input  logic              dmem_arbiter_we1,
    input  logic [ADDR_W-1:0] dmem_arbiter_addr0,
    input  logic [ADDR_W-1:0] dmem_arbiter_addr1,
    input  logic [DATA_W-1:0] dmem_arbiter_wdata0,
    input  logic [DATA_W-1:0] dmem_arbiter_wdata1,
    output logic              dmem_arbiter_ack0,
    output logic              dmem_arbiter_ack1,
    output logic [DATA_W-1:0] dmem_arbiter_rdata0,
    output logic [DATA_W-1:0] dmem_arbiter_rdata1,
    output logic [ADDR_W-1:0] dmem_arbiter_mem_address,
    output logic [DATA_W-1:0] dmem_arbiter_mem_data_in,
    output logic              dmem_arbiter_mem_write,
    output logic              dmem_arbiter_mem_read,
    input  logic [DATA_W-1:0] dmem_arbiter_mem_data_out
);

    state_t             state_q, state_d;
    logic               prio_q, prio_d;
    logic               idx_q, idx_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [DATA_W-1:0]  rd_q, rd_d;

    logic pick_grant;
    logic pick_valid;
    logic pick_prio_next;

    dmem_rr_pick u_pick (
        .req0      (dmem_arbiter_req0),
        .req1      (dmem_arbiter_req1),
        .prio      (prio_q),
        .grant     (pick_grant),
        .valid     (pick_valid),
        .prio_next (pick_prio_next)
    );

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        idx_d   = idx_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = ACCESS;
                    prio_d  = pick_prio_next;
                    idx_d   = pick_grant;
                    we_d    = pick_grant ? dmem_arbiter_we1    : dmem_arbiter_we0;
                    addr_d  = pick_grant ? dmem_arbiter_addr1  : dmem_arbiter_addr0;
                    wdata_d = pick_grant ? dmem_arbiter_wdata1 : dmem_arbiter_wdata0;
                end
            end
            ACCESS: begin
                state_d = RESP;
                // Writes leave the read register untouched so rdata shows the last read.
                if (!we_q) begin
                    rd_d = dmem_arbiter_mem_data_out;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge dmem_arbiter_clk or negedge dmem_arbiter_rst_n) begin
        if (!dmem_arbiter_rst_n) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            idx_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
        end
    end

    // The latch registers only change when entering ACCESS, so driving the DMEM
    // bus straight from them also holds the last values outside ACCESS.
    // Enables and acks decode the state register, so reset clears them at once.
    assign dmem_arbiter_mem_address = addr_q;
    assign dmem_arbiter_mem_data_in = wdata_q;
    assign dmem_arbiter_mem_write   = (state_q == ACCESS) &&  we_q;
    assign dmem_arbiter_mem_read    = (state_q == ACCESS) && !we_q;
    assign dmem_arbiter_ack0        = (state_q == RESP) && !idx_q;
    assign dmem_arbiter_ack1        = (state_q == RESP) &&  idx_q;
    assign dmem_arbiter_rdata0      = rd_q;
    assign dmem_arbiter_rdata1      = rd_q;

endmodule
